dpram_wr_arbiter: RTL and testbench
===================================

# dpram_wr_arbiter

Single-clock controller that shares the write port of `dpram` among `NumReq` requesters with round-robin arbitration. It owns the write and read pointers and the occupancy count, and it drives `dpram`'s `i_wr_en`, `i_wr_ptr`, `i_wr_data`, `i_wr_full`, `i_rd_ptr` and `i_rd_empty`. It sits between a set of producer agents and a `dpram` instance whose `clk_wr` and `clk_rd` are tied to the same clock.

## Interface
- `NumReq`, 4: number of write requesters, ≥2.
- `Depth`, 8: `dpram` depth; must be a power of two, ≥2.
- `Width`, 4: data width.
- `PtrWidth`, `$clog2(Depth)`: pointer width.
- `clk`  input  1  single clock; rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `i_req`  input  NumReq  per-requester write request; bit k = requester k.
- `i_data`  input  NumReq*Width  packed write data; requester k in bits [k*Width +: Width].
- `o_gnt`  output  NumReq  one-hot grant (combinational); a write is accepted on the rising edge that ends a cycle in which the requester's bit is 1.
- `o_wr_en`  output  1  to `dpram` `i_wr_en`; equals |`o_gnt`.
- `o_wr_ptr`  output  PtrWidth  to `dpram` `i_wr_ptr`.
- `o_wr_data`  output  Width  to `dpram` `i_wr_data`; data slice of the granted requester, 0 when there is no grant.
- `o_full`  output  1  to `dpram` `i_wr_full`; count == Depth.
- `i_rd_en`  input  1  read request from the consumer.
- `o_rd_ptr`  output  PtrWidth  to `dpram` `i_rd_ptr`.
- `o_empty`  output  1  to `dpram` `i_rd_empty`; count == 0.
- `o_count`  output  PtrWidth+1  occupancy, 0..Depth.

## Operation
- State registers: `wr_ptr`, `rd_ptr` (PtrWidth each), `count` (PtrWidth+1), `last_gnt` (index, $clog2(NumReq) bits).
- Reset values: `wr_ptr`=0, `rd_ptr`=0, `count`=0, `last_gnt`=NumReq-1. After reset, requester 0 has the highest priority.
- Arbitration (combinational):
  - Scan requesters starting at (`last_gnt`+1) mod NumReq, wrapping.
  - The first k with `i_req`[k]=1 gets `o_gnt`[k]=1, but only when `o_full`=0.
  - When `o_full`=1, `o_gnt`=0 regardless of `i_req`.
- Write accept (`o_wr_en`=1):
  - `wr_ptr` <= `wr_ptr`+1, with natural wrap Depth-1 → 0.
  - `last_gnt` <= granted index.
  - When there is no grant, `last_gnt` holds.
- Read accept (`i_rd_en`=1 and `o_empty`=0): `rd_ptr` <= `rd_ptr`+1, with natural wrap. A read while empty is ignored and changes no state.
- Count update:
  - Write only: +1.
  - Read only: −1.
  - Both in the same cycle: unchanged.
  - Neither: unchanged.
- Full/empty are decided from the registered count only:
  - A write is rejected while full even if a read is accepted in the same cycle.
  - A read is rejected while empty even if a write is accepted in the same cycle.
- Requester protocol:
  - A requester holds `i_req` and its data stable until it sees its `o_gnt` bit.
  - It may drop `i_req` or present new data in the cycle after the grant.
  - Dropping `i_req` without a grant is legal. No state is affected.
- Outputs are combinational from registers: `o_full`, `o_empty`, `o_count`, `o_wr_ptr`=`wr_ptr`, `o_rd_ptr`=`rd_ptr`.

## Timing
- Grant latency: 0 cycles. `o_gnt`, `o_wr_en` and `o_wr_data` are valid in the same cycle as `i_req`.
- The write lands in `dpram` on the next rising edge.
- `o_count`, `o_full` and `o_empty` reflect an accepted operation 1 cycle after acceptance.
- Steady state: one write and one read per cycle are sustainable. Each requester waits at most NumReq-1 grant cycles while not full.
- While `rst_n`=0:
  - `o_gnt`=0, `o_wr_en`=0, `o_wr_data`=0.
  - All registers hold their reset values.
  - `o_empty`=1, `o_full`=0, `o_count`=0.
- Reset asserted mid-operation clears state immediately (asynchronously). An in-flight grant in that cycle is not accepted.

## Test plan
- Reset: drive `i_req`=4'b1111 with `rst_n`=0 → `o_gnt`=0, `o_wr_en`=0, `o_empty`=1, `o_count`=0. Release reset → `o_gnt`=4'b0001.
- Round-robin: hold `i_req`=4'b1111 with `i_rd_en`=1 throughout → grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; `o_count` stays ≤1.
- Sparse requests: `last_gnt`=1 and `i_req`=4'b0011 → `o_gnt`=4'b0001. The next cycle with `i_req`=4'b0011 → `o_gnt`=4'b0010.
- Fill to full with Depth=8, no reads: 8 grants with `o_wr_ptr` 0..7 → `o_count`=8 and `o_full`=1. The 9th request gets `o_gnt`=0. `wr_ptr` wraps to 0.
- Simultaneous boundary operations:
  - At full, `i_req`=1 with `i_rd_en`=1 → read accepted, write rejected, `o_count`=7.
  - At empty, write with `i_rd_en`=1 → write accepted, read ignored, `o_count`=1.
- Mid-operation reset at `o_count`=5: pulse `rst_n` low → `o_count`=0, `o_wr_ptr`=0, `o_rd_ptr`=0, `o_empty`=1 without waiting for a clock edge.

Source files
------------

// File: rtl/dpram_wr_arbiter.sv
// Round-robin write-port arbiter for a single-clock dpram.
// Owns the write/read pointers and the occupancy count.
module dpram_wr_arbiter #(
    parameter int NumReq   = 4,
    parameter int Depth    = 8,
    parameter int Width    = 4,
    parameter int PtrWidth = $clog2(Depth)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NumReq-1:0]       i_req,
    input  logic [NumReq*Width-1:0] i_data,
    output logic [NumReq-1:0]       o_gnt,
    output logic                    o_wr_en,
    output logic [PtrWidth-1:0]     o_wr_ptr,
    output logic [Width-1:0]        o_wr_data,
    output logic                    o_full,
    input  logic                    i_rd_en,
    output logic [PtrWidth-1:0]     o_rd_ptr,
    output logic                    o_empty,
    output logic [PtrWidth:0]       o_count
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [PtrWidth:0] FullCount = (PtrWidth + 1)'(Depth);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [PtrWidth:0]   count;
    logic [IdxW-1:0]     last_gnt;
    logic [IdxW-1:0]     gnt_idx;
    logic [IdxW-1:0]     scan_idx;
    logic                found;
    logic                rd_acc;

    assign o_full   = (count == FullCount);
    assign o_empty  = (count == '0);
    assign o_count  = count;
    assign o_wr_ptr = wr_ptr;
    assign o_rd_ptr = rd_ptr;
    assign o_wr_en  = |o_gnt;
    assign rd_acc   = i_rd_en & ~o_empty;

    // Scan starts just after the last winner; gated off in reset and when full.
    always_comb begin
        o_gnt    = '0;
        gnt_idx  = last_gnt;
        scan_idx = '0;
        found    = 1'b0;
        if (rst_n && !o_full) begin
            for (int off = 1; off <= NumReq; off++) begin
                scan_idx = IdxW'((int'(last_gnt) + off) % NumReq);
                if (!found && i_req[scan_idx]) begin
                    found           = 1'b1;
                    gnt_idx         = scan_idx;
                    o_gnt[scan_idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_wr_data = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (o_gnt[k]) begin
                o_wr_data = i_data[k*Width +: Width];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_gnt <= LastIdx;
        end else begin
            if (o_wr_en) begin
                wr_ptr   <= wr_ptr + PtrWidth'(1);
                last_gnt <= gnt_idx;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            unique case ({o_wr_en, rd_acc})
                2'b10:   count <= count + (PtrWidth + 1)'(1);
                2'b01:   count <= count - (PtrWidth + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_wr_arbiter.sv
// Bench for dpram_wr_arbiter: directed vector table, boundary
// sequences and constrained-random traffic against a queue model.
module tb_dpram_wr_arbiter;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int W  = 4;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  i_req;
    logic [N*W-1:0] i_data;
    logic [N-1:0]  o_gnt;
    logic          o_wr_en;
    logic [PW-1:0] o_wr_ptr;
    logic [W-1:0]  o_wr_data;
    logic          o_full;
    logic          i_rd_en;
    logic [PW-1:0] o_rd_ptr;
    logic          o_empty;
    logic [PW:0]   o_count;

    dpram_wr_arbiter #(
        .NumReq(N), .Depth(D), .Width(W), .PtrWidth(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_data(i_data),
        .o_gnt(o_gnt), .o_wr_en(o_wr_en),
        .o_wr_ptr(o_wr_ptr), .o_wr_data(o_wr_data),
        .o_full(o_full), .i_rd_en(i_rd_en),
        .o_rd_ptr(o_rd_ptr), .o_empty(o_empty),
        .o_count(o_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: FIFO contents as a queue, pointers as plain integers.
    int m_q[$];
    int m_wr;
    int m_rd;
    int m_last;

    typedef struct {
        logic [N-1:0] req;
        logic         rd;
        logic [N-1:0] gnt;
        int           cnt;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic int exp_idx(input logic [N-1:0] req);
        int k;
        if (!rst_n || m_q.size() == D) return -1;
        for (int off = 1; off <= N; off++) begin
            k = (m_last + off) % N;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_wr   = 0;
        m_rd   = 0;
        m_last = N - 1;
    endtask

    task automatic check_all();
        int g;
        logic [N-1:0] eg;
        logic [W-1:0] ed;
        g  = exp_idx(i_req);
        eg = '0;
        ed = '0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            ed    = i_data[g*W +: W];
        end
        chk("gnt", 32'(o_gnt), 32'(eg));
        chk("wr_en", 32'(o_wr_en), 32'(g >= 0));
        chk("wr_data", 32'(o_wr_data), 32'(ed));
        chk("full", 32'(o_full), 32'(m_q.size() == D));
        chk("empty", 32'(o_empty), 32'(m_q.size() == 0));
        chk("count", 32'(o_count), 32'(m_q.size()));
        chk("wr_ptr", 32'(o_wr_ptr), 32'(m_wr));
        chk("rd_ptr", 32'(o_rd_ptr), 32'(m_rd));
    endtask

    // Entered at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic [N-1:0] req, input logic rd);
        int   g;
        logic rd_ok;
        i_req   = req;
        i_rd_en = rd;
        #1;
        check_all();
        g     = exp_idx(req);
        rd_ok = rd && (m_q.size() > 0);
        @(posedge clk);
        if (rd_ok) begin
            void'(m_q.pop_front());
            m_rd = (m_rd + 1) % D;
        end
        if (g >= 0) begin
            m_q.push_back(int'(i_data[g*W +: W]));
            m_wr   = (m_wr + 1) % D;
            m_last = g;
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        i_req   = '0;
        i_rd_en = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        #1;
        chk("rst_count", 32'(o_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0]   req;
        logic [N-1:0]   prev_gnt;
        logic [N*W-1:0] dat;
        logic           rd;

        tv[0] = '{4'b1111, 1'b1, 4'b0001, 0};
        tv[1] = '{4'b1111, 1'b1, 4'b0010, 1};
        tv[2] = '{4'b1111, 1'b1, 4'b0100, 1};
        tv[3] = '{4'b1111, 1'b1, 4'b1000, 1};
        tv[4] = '{4'b1111, 1'b1, 4'b0001, 1};
        tv[5] = '{4'b0010, 1'b1, 4'b0010, 1};
        tv[6] = '{4'b0011, 1'b1, 4'b0001, 1};
        tv[7] = '{4'b0011, 1'b1, 4'b0010, 1};
        tv[8] = '{4'b0000, 1'b1, 4'b0000, 1};
        tv[9] = '{4'b0000, 1'b0, 4'b0000, 0};

        // Reset with all requesters asserted.
        rst_n   = 1'b0;
        i_req   = 4'b1111;
        i_rd_en = 1'b0;
        i_data  = 16'h4321;
        model_reset();
        #2;
        chk("rst_gnt", 32'(o_gnt), 32'd0);
        chk("rst_wr_en", 32'(o_wr_en), 32'd0);
        chk("rst_wr_data", 32'(o_wr_data), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin and sparse-request table.
        for (int i = 0; i < 10; i++) begin
            i_data  = N*W'($urandom());
            i_req   = tv[i].req;
            i_rd_en = tv[i].rd;
            #1;
            chk($sformatf("tv%0d_gnt", i), 32'(o_gnt), 32'(tv[i].gnt));
            chk($sformatf("tv%0d_cnt", i), 32'(o_count), 32'(tv[i].cnt));
            cycle(tv[i].req, tv[i].rd);
        end

        // Fill to full, then boundary operations.
        reset_dut();
        i_data = 16'h9a5c;
        for (int i = 0; i < D; i++) begin
            i_req = 4'b0001;
            #1;
            chk("fill_wr_ptr", 32'(o_wr_ptr), 32'(i));
            cycle(4'b0001, 1'b0);
        end
        i_req = 4'b0001;
        #1;
        chk("full_count", 32'(o_count), 32'(D));
        chk("full_flag", 32'(o_full), 32'd1);
        chk("full_gnt", 32'(o_gnt), 32'd0);
        chk("wrap_wr_ptr", 32'(o_wr_ptr), 32'd0);
        cycle(4'b0001, 1'b0);
        i_rd_en = 1'b1;
        #1;
        chk("full_rw_gnt", 32'(o_gnt), 32'd0);
        cycle(4'b0001, 1'b1);
        #1;
        chk("full_rw_count", 32'(o_count), 32'(D - 1));
        repeat (D - 1) cycle(4'b0000, 1'b1);
        #1;
        chk("drain_empty", 32'(o_empty), 32'd1);
        cycle(4'b0001, 1'b1);
        #1;
        chk("empty_rw_count", 32'(o_count), 32'd1);

        // Asynchronous reset with count at 5.
        repeat (4) cycle(4'b0001, 1'b0);
        i_req   = 4'b1111;
        i_rd_en = 1'b0;
        #1;
        chk("pre_rst_count", 32'(o_count), 32'd5);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_count", 32'(o_count), 32'd0);
        chk("arst_wr_ptr", 32'(o_wr_ptr), 32'd0);
        chk("arst_rd_ptr", 32'(o_rd_ptr), 32'd0);
        chk("arst_empty", 32'(o_empty), 32'd1);
        chk("arst_gnt", 32'(o_gnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic obeying the hold-until-granted protocol.
        req      = '0;
        prev_gnt = '0;
        dat      = '0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (req[k] && !prev_gnt[k]) begin
                    if ($urandom_range(0, 15) == 0) req[k] = 1'b0;
                end else begin
                    req[k]         = 1'($urandom_range(0, 1));
                    dat[k*W +: W] = W'($urandom());
                end
            end
            rd = ($urandom_range(0, 99) < ((c % 200) < 100 ? 30 : 75));
            i_req  = req;
            i_data = dat;
            #1;
            prev_gnt = o_gnt;
            cycle(req, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
